maxpool_fp: RTL and testbench
=============================

# maxpool_fp

Streaming 1-D max-pool stage that sits directly downstream of the batch-norm/ReLU stage. It consumes one NO_CH-wide vector per valid cycle, one vector per time step. For every POOL consecutive valid vectors it emits the per-channel maximum. Frame boundaries are tracked so each frame of FRAME_LEN inputs produces a fixed number of outputs, with the final one flagged.

## Interface
- Reset is synchronous and active-high; the block has one clock.
- NO_CH, default 10: number of channels per vector.
- BW, default 12: bits per channel, for both input and output.
- POOL, default 2: window length in input vectors, ≥ 2.
- FRAME_LEN, default 128: valid inputs per frame, ≥ 1.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- vld_in  input  1  data_in valid this cycle; gaps are allowed and there is no backpressure.
- data_in  input  [NO_CH-1:0][BW-1:0]  per-channel input, taken from ReLU output.
- vld_out  output  1  one-cycle pulse when data_out holds a pooled vector.
- data_out  output  [NO_CH-1:0][BW-1:0]  per-channel window maximum.
- last_out  output  1  high together with vld_out on the final output of a frame.

## Operation
- Compare inputs as unsigned. ReLU upstream guarantees non-negative values, so unsigned compare equals signed compare.
- State registers:
  - win_cnt, 0..POOL-1: position within the current window.
  - frm_cnt, 0..FRAME_LEN-1: position within the current frame.
  - acc[NO_CH]: running maximum.
- Window rules on a cycle with vld_in=1:
  - If win_cnt==0: acc <= data_in.
  - Otherwise: acc[i] <= max(acc[i], data_in[i]).
  - win_cnt increments and wraps to 0 after POOL-1.
- Window completion (vld_in=1 and win_cnt==POOL-1):
  - data_out[i] <= max(acc[i], data_in[i]), computed combinationally from the current input.
  - vld_out <= 1.
- frm_cnt increments on each vld_in and wraps after FRAME_LEN-1.
- Frame end (vld_in=1 and frm_cnt==FRAME_LEN-1):
  - win_cnt <= 0 regardless of its current value.
  - If this input also completes a window, last_out <= 1 with that output.
  - If the window is partial, the result depends on the macro (see Configuration).
- Cycles with vld_in=0 change nothing except that vld_out and last_out drop to 0.
- Ties produce the equal value; no index is tracked.

## Timing
- Latency: vld_out is asserted exactly 1 cycle after the vld_in cycle of the window's last input.
- vld_out and last_out are single-cycle pulses.
- data_out holds its value until the next output.
- Peak output rate is one output per POOL valid inputs. Back-to-back vld_in with no gaps is supported indefinitely.
- Reset values:
  - vld_out=0, last_out=0, data_out=0.
  - win_cnt=0, frm_cnt=0, acc=0.
- Reset asserted mid-window or mid-frame discards the partial window and frame. The first vld_in after rst deasserts starts a new frame and a new window.
- vld_in sampled while rst=1 is ignored.

## Configuration
- Macro `MAXPOOL_CEIL_EN` controls partial windows at frame end.
- Without it (floor mode):
  - When FRAME_LEN % POOL != 0, the trailing partial window is discarded with no output.
  - last_out accompanies the last full-window output, i.e. output number FRAME_LEN/POOL (integer division).
  - Outputs per frame = floor(FRAME_LEN/POOL).
- With it (ceil mode):
  - The trailing partial window is emitted at frame end. data_out = max over the received inputs including the current one. vld_out=1 and last_out=1 with 1-cycle latency.
  - Outputs per frame = ceil(FRAME_LEN/POOL).
- When FRAME_LEN % POOL == 0, both modes behave identically.

## Test plan
- **Basic pool.** NO_CH=2, POOL=2. Inputs {3,9} then {7,4}, back-to-back. Expect one cycle later: vld_out=1, data_out={7,9}, then vld_out=0.
- **Gapped input.** POOL=3. Inputs 5, 12, 1 on channel 0, separated by 2 idle cycles each. Expect a single output of 12, exactly 1 cycle after the third input; no vld_out before that.
- **Frame end, floor mode.** FRAME_LEN=5, POOL=2, macro off. Feed 5 inputs 1..5. Expect outputs 2 and 4 only, last_out on 4. The 6th input starts a new window: inputs 6, 7 yield 7 with last_out=0.
- **Frame end, ceil mode.** Same stimulus with `MAXPOOL_CEIL_EN` defined. Expect outputs 2, 4, 5; last_out=1 only on 5; 5 appears 1 cycle after input 5.
- **Reset mid-window.** POOL=2. Feed 100, assert rst for 1 cycle, then feed 3, 4. Expect a single output of 4 (not 100), and data_out=0 and vld_out=0 during and immediately after reset.
- **Full range.** BW=12. Inputs 0xFFF, 0x000 and 0x000, 0x7FF across two windows. Expect 0xFFF then 0x7FF, confirming unsigned compare. Run 1000 random back-to-back vectors against a reference model with zero mismatches.

Source files
------------

// File: rtl/maxpool_fp.sv
// Streaming 1-D per-channel max-pool with frame tracking and a flagged final output.
// Define MAXPOOL_CEIL_EN to emit the trailing partial window at frame end (ceil mode).
module maxpool_fp #(
  parameter int unsigned NO_CH     = 10,
  parameter int unsigned BW        = 12,
  parameter int unsigned POOL      = 2,
  parameter int unsigned FRAME_LEN = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld_in,
  input  logic [NO_CH-1:0][BW-1:0]   data_in,
  output logic                       vld_out,
  output logic [NO_CH-1:0][BW-1:0]   data_out,
  output logic                       last_out
);

  localparam int unsigned WW = $clog2(POOL);
  localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

`ifdef MAXPOOL_CEIL_EN
  localparam logic        CEIL_MODE = 1'b1;
  localparam logic        HAS_LAST  = 1'b1;
  localparam int unsigned LAST_IDX  = FRAME_LEN - 1;
`else
  // Floor mode flags the last full window; a frame shorter than POOL has none.
  localparam int unsigned NUM_FULL  = FRAME_LEN / POOL;
  localparam logic        CEIL_MODE = 1'b0;
  localparam logic        HAS_LAST  = (NUM_FULL > 0) ? 1'b1 : 1'b0;
  localparam int unsigned LAST_IDX  = (NUM_FULL > 0) ? (NUM_FULL * POOL - 1) : 0;
`endif

  logic [WW-1:0]              win_cnt;
  logic [FW-1:0]              frm_cnt;
  logic [NO_CH-1:0][BW-1:0]   acc;

  logic [NO_CH-1:0][BW-1:0]   max_c;
  logic                       win_last_c;
  logic                       frm_last_c;
  logic                       emit_c;
  logic                       last_c;

  // Running maximum including the current input; a fresh window starts from data_in.
  always_comb begin
    max_c      = data_in;
    win_last_c = (win_cnt == WW'(POOL - 1));
    frm_last_c = (frm_cnt == FW'(FRAME_LEN - 1));
    emit_c     = win_last_c || (CEIL_MODE && frm_last_c);
    last_c     = emit_c && HAS_LAST && (frm_cnt == FW'(LAST_IDX));
    if (win_cnt != '0) begin
      for (int i = 0; i < int'(NO_CH); i++) begin
        max_c[i] = (acc[i] > data_in[i]) ? acc[i] : data_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt  <= '0;
      frm_cnt  <= '0;
      acc      <= '0;
      vld_out  <= 1'b0;
      last_out <= 1'b0;
      data_out <= '0;
    end else begin
      vld_out  <= 1'b0;
      last_out <= 1'b0;
      if (vld_in) begin
        acc      <= max_c;
        win_cnt  <= (win_last_c || frm_last_c) ? '0 : win_cnt + WW'(1);
        frm_cnt  <= frm_last_c ? '0 : frm_cnt + FW'(1);
        vld_out  <= emit_c;
        last_out <= last_c;
        if (emit_c) begin
          data_out <= max_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_fp.sv
// Directed bench for maxpool_fp: two instances (POOL=2/FRAME_LEN=5 and POOL=3) share stimulus.
module tb_maxpool_fp;

  logic             clk;
  logic             rst;
  logic             vld_in;
  logic [1:0][11:0] data_in;

  logic             vld_a, last_a;
  logic [1:0][11:0] data_a;
  logic             vld_b, last_b;
  logic [1:0][11:0] data_b;

  int checks   = 0;
  int failures = 0;

`ifdef MAXPOOL_CEIL_EN
  localparam bit CEIL = 1'b1;
`else
  localparam bit CEIL = 1'b0;
`endif

  maxpool_fp #(.NO_CH(2), .BW(12), .POOL(2), .FRAME_LEN(5)) dut_a (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
    .vld_out(vld_a), .data_out(data_a), .last_out(last_a)
  );

  maxpool_fp #(.NO_CH(2), .BW(12), .POOL(3), .FRAME_LEN(128)) dut_b (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
    .vld_out(vld_b), .data_out(data_b), .last_out(last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [11:0] d1, input logic [11:0] d0);
    vld_in  = v;
    data_in = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 12'd0, 12'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] r0, r1, p0, p1, e0, e1;
    int          pos;
    bit          e_vld, e_last;

    rst = 1'b1; vld_in = 1'b0; data_in = '0;
    step(1'b0, 12'd0, 12'd0);
    step(1'b0, 12'd0, 12'd0);
    chk("reset_vld_a",  32'(vld_a),  32'd0);
    chk("reset_last_a", 32'(last_a), 32'd0);
    chk("reset_data_a", 32'(data_a), 32'd0);
    chk("reset_vld_b",  32'(vld_b),  32'd0);
    chk("reset_data_b", 32'(data_b), 32'd0);
    rst = 1'b0;

    // Basic pool: {3,9} then {7,4} -> {7,9}
    step(1'b1, 12'd3, 12'd9);
    chk("basic_vld_first", 32'(vld_a), 32'd0);
    step(1'b1, 12'd7, 12'd4);
    chk("basic_vld",  32'(vld_a),  32'd1);
    chk("basic_data", 32'(data_a), {8'd0, 12'd7, 12'd9});
    chk("basic_last", 32'(last_a), 32'd0);
    step(1'b0, 12'd0, 12'd0);
    chk("basic_vld_drop",  32'(vld_a),  32'd0);
    chk("basic_data_hold", 32'(data_a), {8'd0, 12'd7, 12'd9});

    // Gapped input on POOL=3 instance: 5, 12, 1 with two idle cycles between
    do_reset();
    step(1'b1, 12'd0, 12'd5);
    chk("gap_vld_in1", 32'(vld_b), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 12'd0, 12'd0);
      chk("gap_vld_idle1", 32'(vld_b), 32'd0);
    end
    step(1'b1, 12'd0, 12'd12);
    chk("gap_vld_in2", 32'(vld_b), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 12'd0, 12'd0);
      chk("gap_vld_idle2", 32'(vld_b), 32'd0);
    end
    step(1'b1, 12'd0, 12'd1);
    chk("gap_vld",  32'(vld_b),  32'd1);
    chk("gap_data", 32'(data_b[0]), 32'd12);
    chk("gap_last", 32'(last_b), 32'd0);
    step(1'b0, 12'd0, 12'd0);
    chk("gap_vld_drop", 32'(vld_b), 32'd0);

    // Frame end, FRAME_LEN=5, POOL=2
    do_reset();
    step(1'b1, 12'd1, 12'd1);
    chk("frm_in1_vld", 32'(vld_a), 32'd0);
    step(1'b1, 12'd2, 12'd2);
    chk("frm_in2_vld",  32'(vld_a),  32'd1);
    chk("frm_in2_data", 32'(data_a[0]), 32'd2);
    chk("frm_in2_last", 32'(last_a), 32'd0);
    step(1'b1, 12'd3, 12'd3);
    chk("frm_in3_vld", 32'(vld_a), 32'd0);
    step(1'b1, 12'd4, 12'd4);
    chk("frm_in4_vld",  32'(vld_a),  32'd1);
    chk("frm_in4_data", 32'(data_a[1]), 32'd4);
    chk("frm_in4_last", 32'(last_a), CEIL ? 32'd0 : 32'd1);
    step(1'b1, 12'd5, 12'd5);
    chk("frm_in5_vld",  32'(vld_a),  CEIL ? 32'd1 : 32'd0);
    chk("frm_in5_data", 32'(data_a[0]), CEIL ? 32'd5 : 32'd4);
    chk("frm_in5_last", 32'(last_a), CEIL ? 32'd1 : 32'd0);
    step(1'b1, 12'd6, 12'd6);
    chk("frm_in6_vld", 32'(vld_a), 32'd0);
    step(1'b1, 12'd7, 12'd7);
    chk("frm_in7_vld",  32'(vld_a),  32'd1);
    chk("frm_in7_data", 32'(data_a[0]), 32'd7);
    chk("frm_in7_last", 32'(last_a), 32'd0);

    // Reset mid-window; vld_in during reset is ignored
    do_reset();
    step(1'b1, 12'd100, 12'd100);
    chk("rstw_vld_in1", 32'(vld_a), 32'd0);
    rst = 1'b1;
    step(1'b1, 12'd200, 12'd200);
    chk("rstw_vld_during",  32'(vld_a),  32'd0);
    chk("rstw_data_during", 32'(data_a), 32'd0);
    rst = 1'b0;
    step(1'b0, 12'd0, 12'd0);
    chk("rstw_vld_after",  32'(vld_a),  32'd0);
    chk("rstw_data_after", 32'(data_a), 32'd0);
    step(1'b1, 12'd3, 12'd3);
    chk("rstw_vld_in3", 32'(vld_a), 32'd0);
    step(1'b1, 12'd4, 12'd4);
    chk("rstw_vld",  32'(vld_a),  32'd1);
    chk("rstw_data", 32'(data_a), {8'd0, 12'd4, 12'd4});

    // Full range unsigned compare
    do_reset();
    step(1'b1, 12'hFFF, 12'hFFF);
    step(1'b1, 12'h000, 12'h000);
    chk("range_vld1",  32'(vld_a),  32'd1);
    chk("range_data1", 32'(data_a), {8'd0, 12'hFFF, 12'hFFF});
    step(1'b1, 12'h000, 12'h000);
    step(1'b1, 12'h7FF, 12'h7FF);
    chk("range_vld2",  32'(vld_a),  32'd1);
    chk("range_data2", 32'(data_a), {8'd0, 12'h7FF, 12'h7FF});

    // Random back-to-back vectors against a frame-position model
    do_reset();
    pos = 0; p0 = '0; p1 = '0;
    for (int i = 0; i < 1000; i++) begin
      r0 = 12'($urandom_range(0, 4095));
      r1 = 12'($urandom_range(0, 4095));
      e_vld  = (pos == 1) || (pos == 3) || (CEIL && pos == 4);
      e_last = CEIL ? (pos == 4) : (pos == 3);
      if (pos == 4) begin
        e0 = r0; e1 = r1;
      end else begin
        e0 = (p0 > r0) ? p0 : r0;
        e1 = (p1 > r1) ? p1 : r1;
      end
      step(1'b1, r1, r0);
      chk("rand_vld", 32'(vld_a), 32'(e_vld));
      if (e_vld) begin
        chk("rand_data", 32'(data_a), {8'd0, e1, e0});
        chk("rand_last", 32'(last_a), 32'(e_last));
      end
      p0 = r0; p1 = r1;
      pos = (pos == 4) ? 0 : pos + 1;
    end
    step(1'b0, 12'd0, 12'd0);
    chk("rand_idle_vld", 32'(vld_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
